// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register byte addresses and CTRL bit positions.
package gpio_pkg;

  localparam logic [7:0] ADR_IN      = 8'h00;
  localparam logic [7:0] ADR_OUT     = 8'h04;
  localparam logic [7:0] ADR_OE      = 8'h08;
  localparam logic [7:0] ADR_INTE    = 8'h0C;
  localparam logic [7:0] ADR_PTRIG   = 8'h10;
  localparam logic [7:0] ADR_NTRIG   = 8'h14;
  localparam logic [7:0] ADR_CTRL    = 8'h18;
  localparam logic [7:0] ADR_INTS    = 8'h1C;
  localparam logic [7:0] ADR_OUT_SET = 8'h20;
  localparam logic [7:0] ADR_OUT_CLR = 8'h24;
  localparam logic [7:0] ADR_DEB     = 8'h28;
  localparam logic [7:0] ADR_LEVEL   = 8'h2C;

  localparam int CTRL_INTE_BIT = 0;
  localparam int CTRL_INTS_BIT = 1;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin pad synchroniser followed by a threshold debouncer.
// A zero threshold bypasses the counter so IN follows the synchroniser directly.
module gpio_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad,
  input  logic [DEB_W-1:0] thr,
  output logic             deb
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic                   deb_r;
  logic [DEB_W-1:0]       cnt_r;
  logic [DEB_W:0]         cnt_nxt_s;
  logic                   bypass_s;

  assign sync_s    = sync_r[SYNC_STAGES-1];
  assign bypass_s  = (thr == {DEB_W{1'b0}});
  assign cnt_nxt_s = {1'b0, cnt_r} + {{DEB_W{1'b0}}, 1'b1};

  // Synchroniser shift, debounce counter and stable-value register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      cnt_r  <= {DEB_W{1'b0}};
      deb_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
      // deb_r keeps tracking in bypass so raising the threshold later starts glitch-free
      if (bypass_s) begin
        deb_r <= sync_s;
        cnt_r <= {DEB_W{1'b0}};
      end else if (sync_s == deb_r) begin
        cnt_r <= {DEB_W{1'b0}};
      end else if (cnt_nxt_s >= {1'b0, thr}) begin
        deb_r <= sync_s;
        cnt_r <= {DEB_W{1'b0}};
      end else begin
        cnt_r <= cnt_nxt_s[DEB_W-1:0];
      end
    end
  end

  // Select bypass or debounced value; both sources are flops.
  always_comb begin
    if (bypass_s) begin
      deb = sync_s;
    end else begin
      deb = deb_r;
    end
  end

endmodule

// File: rtl/gpio_bank_irq.sv
// Parametrised GPIO bank with per-pin debounce, edge/level interrupts,
// write-1-to-clear status and atomic output set/clear.
module gpio_bank_irq
  import gpio_pkg::*;
#(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              gpio_we,
  input  logic [7:0]        gpio_adr,
  input  logic [31:0]       gpio_dat_i,
  output logic [31:0]       gpio_dat_o,
  output logic              gpio_inta_o,
  output logic [GPIO_W-1:0] out_pad_o,
  output logic [GPIO_W-1:0] oen_padoe_o,
  input  logic [GPIO_W-1:0] in_pad_i
);

  logic [GPIO_W-1:0] deb_s;
  logic [GPIO_W-1:0] deb_prev_r;
  logic [GPIO_W-1:0] out_r;
  logic [GPIO_W-1:0] oe_r;
  logic [GPIO_W-1:0] inte_r;
  logic [GPIO_W-1:0] ptrig_r;
  logic [GPIO_W-1:0] ntrig_r;
  logic [GPIO_W-1:0] level_r;
  logic [GPIO_W-1:0] ints_r;
  logic [DEB_W-1:0]  deb_thr_r;
  logic              ctrl_inte_r;
  logic [31:0]       dat_o_r;
  logic [31:0]       rd_s;
  logic [GPIO_W-1:0] wd_s;
  logic [7:0]        wa_s;
  logic [GPIO_W-1:0] w1c_s;
  logic [GPIO_W-1:0] set_s;
  logic              unused_s;

  assign wd_s     = gpio_dat_i[GPIO_W-1:0];
  assign wa_s     = {gpio_adr[7:2], 2'b00};
  assign unused_s = ^{gpio_adr[1:0], gpio_dat_i};

  for (genvar g = 0; g < GPIO_W; g++) begin : g_pin
    gpio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W)
    ) u_deb (
      .clk (sys_clk),
      .rst (sys_rst),
      .pad (in_pad_i[g]),
      .thr (deb_thr_r),
      .deb (deb_s[g])
    );
  end

  // Interrupt set sources and the write-1-to-clear mask.
  always_comb begin
    set_s = inte_r & ((level_r  & ((deb_s & ptrig_r) | (~deb_s & ntrig_r))) |
                      (~level_r & (((deb_s & ~deb_prev_r) & ptrig_r) |
                                   ((~deb_s & deb_prev_r) & ntrig_r))));
    if (gpio_we && (wa_s == ADR_INTS)) begin
      w1c_s = wd_s;
    end else begin
      w1c_s = {GPIO_W{1'b0}};
    end
  end

  // Read data mux; unmapped and write-only addresses return zero.
  always_comb begin
    rd_s = 32'd0;
    case (wa_s)
      ADR_IN:    rd_s[GPIO_W-1:0] = deb_s;
      ADR_OUT:   rd_s[GPIO_W-1:0] = out_r;
      ADR_OE:    rd_s[GPIO_W-1:0] = oe_r;
      ADR_INTE:  rd_s[GPIO_W-1:0] = inte_r;
      ADR_PTRIG: rd_s[GPIO_W-1:0] = ptrig_r;
      ADR_NTRIG: rd_s[GPIO_W-1:0] = ntrig_r;
      ADR_CTRL: begin
        rd_s[CTRL_INTE_BIT] = ctrl_inte_r;
        rd_s[CTRL_INTS_BIT] = |ints_r;
      end
      ADR_INTS:  rd_s[GPIO_W-1:0] = ints_r;
      ADR_DEB:   rd_s[DEB_W-1:0]  = deb_thr_r;
      ADR_LEVEL: rd_s[GPIO_W-1:0] = level_r;
      default:   rd_s = 32'd0;
    endcase
  end

  // Register file, interrupt status and registered read port.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_r       <= {GPIO_W{1'b0}};
      oe_r        <= {GPIO_W{1'b0}};
      inte_r      <= {GPIO_W{1'b0}};
      ptrig_r     <= {GPIO_W{1'b0}};
      ntrig_r     <= {GPIO_W{1'b0}};
      level_r     <= {GPIO_W{1'b0}};
      ints_r      <= {GPIO_W{1'b0}};
      deb_prev_r  <= {GPIO_W{1'b0}};
      deb_thr_r   <= {DEB_W{1'b0}};
      ctrl_inte_r <= 1'b0;
      dat_o_r     <= 32'd0;
    end else begin
      deb_prev_r <= deb_s;
      // set is ORed after the clear so a coincident event wins over W1C
      ints_r     <= (ints_r & ~w1c_s) | set_s;
      if (gpio_we) begin
        case (wa_s)
          ADR_OUT:     out_r       <= wd_s;
          ADR_OE:      oe_r        <= wd_s;
          ADR_INTE:    inte_r      <= wd_s;
          ADR_PTRIG:   ptrig_r     <= wd_s;
          ADR_NTRIG:   ntrig_r     <= wd_s;
          ADR_CTRL:    ctrl_inte_r <= gpio_dat_i[CTRL_INTE_BIT];
          ADR_OUT_SET: out_r       <= out_r | wd_s;
          ADR_OUT_CLR: out_r       <= out_r & ~wd_s;
          ADR_DEB:     deb_thr_r   <= gpio_dat_i[DEB_W-1:0];
          ADR_LEVEL:   level_r     <= wd_s;
          default:     ;
        endcase
      end else begin
        dat_o_r <= rd_s;
      end
    end
  end

  assign gpio_dat_o  = dat_o_r;
  assign out_pad_o   = out_r;
  assign oen_padoe_o = oe_r;
  assign gpio_inta_o = ctrl_inte_r & (|ints_r);

endmodule

// File: tb/tb_gpio_bank_irq.sv
// Directed bench for gpio_bank_irq: register table plus hand-timed debounce and interrupt sequences.
module tb_gpio_bank_irq;
  import gpio_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        gpio_we;
  logic [7:0]  gpio_adr;
  logic [31:0] gpio_dat_i;
  logic [31:0] gpio_dat_o;
  logic        gpio_inta_o;
  logic [31:0] out_pad_o;
  logic [31:0] oen_padoe_o;
  logic [31:0] in_pad_i;

  logic        we8;
  logic [7:0]  adr8;
  logic [31:0] dat_i8;
  logic [31:0] dat_o8;
  logic        inta8;
  logic [7:0]  out8;
  logic [7:0]  oe8;
  logic [7:0]  in8;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  gpio_bank_irq #(.GPIO_W(32), .SYNC_STAGES(2), .DEB_W(4)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .gpio_we     (gpio_we),
    .gpio_adr    (gpio_adr),
    .gpio_dat_i  (gpio_dat_i),
    .gpio_dat_o  (gpio_dat_o),
    .gpio_inta_o (gpio_inta_o),
    .out_pad_o   (out_pad_o),
    .oen_padoe_o (oen_padoe_o),
    .in_pad_i    (in_pad_i)
  );

  gpio_bank_irq #(.GPIO_W(8), .SYNC_STAGES(2), .DEB_W(4)) dut8 (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .gpio_we     (we8),
    .gpio_adr    (adr8),
    .gpio_dat_i  (dat_i8),
    .gpio_dat_o  (dat_o8),
    .gpio_inta_o (inta8),
    .out_pad_o   (out8),
    .oen_padoe_o (oe8),
    .in_pad_i    (in8)
  );

  typedef struct {
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [7:0]  ra;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All stimulus changes happen at the falling edge; writes are captured at the next rising edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    gpio_we    = 1'b1;
    gpio_adr   = a;
    gpio_dat_i = d;
    @(negedge sys_clk);
    gpio_we    = 1'b0;
    gpio_dat_i = 32'd0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    gpio_we  = 1'b0;
    gpio_adr = a;
    @(negedge sys_clk);
    d = gpio_dat_o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset;
    sys_rst = 1'b1;
    idle(2);
    sys_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        glitch_seen;

    tbl[0]  = '{ADR_OE,      32'hFFFF0000, ADR_OE,      32'hFFFF0000, "oe_rw"};
    tbl[1]  = '{ADR_OUT,     32'hA5A5A5A5, ADR_OUT,     32'hA5A5A5A5, "out_rw"};
    tbl[2]  = '{ADR_OUT_SET, 32'h0000000A, ADR_OUT,     32'hA5A5A5AF, "out_set"};
    tbl[3]  = '{ADR_OUT_CLR, 32'h00000005, ADR_OUT,     32'hA5A5A5AA, "out_clr"};
    tbl[4]  = '{8'h30,       32'hFFFFFFFF, 8'h30,       32'h00000000, "unmapped"};
    tbl[5]  = '{8'h30,       32'h00000000, ADR_OUT_SET, 32'h00000000, "out_set_reads0"};
    tbl[6]  = '{ADR_DEB,     32'hFFFFFFFF, ADR_DEB,     32'h0000000F, "deb_width"};
    tbl[7]  = '{ADR_DEB,     32'h00000000, ADR_DEB,     32'h00000000, "deb_zero"};
    tbl[8]  = '{ADR_LEVEL,   32'h0F0F0F0F, ADR_LEVEL,   32'h0F0F0F0F, "level_rw"};
    tbl[9]  = '{ADR_PTRIG,   32'h12340000, ADR_PTRIG,   32'h12340000, "ptrig_rw"};
    tbl[10] = '{ADR_CTRL,    32'h00000003, ADR_CTRL,    32'h00000001, "ctrl_inte_only"};
    tbl[11] = '{ADR_INTE,    32'h0000FFFF, 8'h31,       32'h00000000, "inte_rd_via_alias"};

    gpio_we    = 1'b0;
    gpio_adr   = 8'h00;
    gpio_dat_i = 32'd0;
    in_pad_i   = 32'd0;
    we8        = 1'b0;
    adr8       = 8'h00;
    dat_i8     = 32'd0;
    in8        = 8'd0;

    // Reset and read-back of every address.
    sys_rst = 1'b1;
    idle(2);
    chk("rst_dat_o", gpio_dat_o, 32'd0);
    chk("rst_inta", {31'd0, gpio_inta_o}, 32'd0);
    chk("rst_out_pad", out_pad_o, 32'd0);
    chk("rst_oe_pad", oen_padoe_o, 32'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rd(8'(i * 4), d);
      chk("rst_read", d, 32'd0);
    end

    // Register table.
    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].ra, d);
      chk(tbl[i].name, d, tbl[i].exp);
    end
    rd(ADR_INTE, d);
    chk("inte_rd", d, 32'h0000FFFF);
    chk("pad_oe", oen_padoe_o, 32'hFFFF0000);
    chk("pad_out", out_pad_o, 32'hA5A5A5AA);

    // Write-cycle hold of read data.
    rd(ADR_OUT, d);
    wr(ADR_OUT, 32'h00000000);
    chk("dat_o_hold_on_write", gpio_dat_o, 32'hA5A5A5AA);
    chk("out_pad_same_edge", out_pad_o, 32'h00000000);

    // DEB=0: synchroniser latency.
    do_reset();
    gpio_adr = ADR_IN;
    in_pad_i = 32'h12345678;
    idle(2);
    chk("in_early", gpio_dat_o, 32'd0);
    idle(1);
    chk("in_bypass", gpio_dat_o, 32'h12345678);

    // DEB=3: short glitch is filtered, a steady level passes after SYNC+3 cycles.
    in_pad_i = 32'd0;
    do_reset();
    wr(ADR_DEB, 32'd3);
    gpio_adr = ADR_IN;
    idle(4);
    in_pad_i = 32'h1;
    idle(2);
    in_pad_i = 32'h0;
    glitch_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      glitch_seen = glitch_seen | gpio_dat_o[0];
    end
    chk("glitch_filtered", {31'd0, glitch_seen}, 32'd0);
    rd(ADR_INTS, d);
    chk("glitch_ints", d, 32'd0);
    gpio_adr = ADR_IN;
    idle(1);
    in_pad_i = 32'h1;
    idle(5);
    chk("deb_not_yet", gpio_dat_o, 32'd0);
    idle(1);
    chk("deb_pass", gpio_dat_o, 32'd1);

    // Edge interrupts.
    in_pad_i = 32'h2;
    do_reset();
    idle(4);
    wr(ADR_INTE, 32'd3);
    wr(ADR_PTRIG, 32'd1);
    wr(ADR_NTRIG, 32'd2);
    wr(ADR_CTRL, 32'd1);
    rd(ADR_INTS, d);
    chk("edge_idle", d, 32'd0);
    in_pad_i = 32'h3;
    idle(4);
    chk("edge_inta", {31'd0, gpio_inta_o}, 32'd1);
    rd(ADR_INTS, d);
    chk("edge_rise", d, 32'd1);
    in_pad_i = 32'h1;
    idle(4);
    rd(ADR_INTS, d);
    chk("edge_fall", d, 32'd3);
    wr(ADR_INTS, 32'd1);
    rd(ADR_INTS, d);
    chk("w1c", d, 32'd2);
    in_pad_i = 32'h0;
    idle(4);
    rd(ADR_INTS, d);
    chk("no_ntrig0", d, 32'd2);
    in_pad_i = 32'h1;
    idle(2);
    wr(ADR_INTS, 32'd1);
    rd(ADR_INTS, d);
    chk("set_beats_w1c", d, 32'd3);
    wr(ADR_CTRL, 32'd0);
    chk("inta_masked", {31'd0, gpio_inta_o}, 32'd0);

    // Level interrupts.
    in_pad_i = 32'h0;
    do_reset();
    in_pad_i = 32'h1;
    idle(3);
    wr(ADR_LEVEL, 32'd1);
    wr(ADR_PTRIG, 32'd1);
    wr(ADR_INTE, 32'd1);
    wr(ADR_CTRL, 32'd1);
    idle(1);
    rd(ADR_INTS, d);
    chk("level_set", d, 32'd1);
    rd(ADR_CTRL, d);
    chk("ctrl_summary", d, 32'd3);
    wr(ADR_INTS, 32'd1);
    rd(ADR_INTS, d);
    chk("level_reasserts", d, 32'd1);
    in_pad_i = 32'h0;
    idle(4);
    wr(ADR_INTS, 32'd1);
    rd(ADR_INTS, d);
    chk("level_cleared", d, 32'd0);
    chk("level_inta", {31'd0, gpio_inta_o}, 32'd0);

    // Narrow instance: zero extension above GPIO_W.
    we8    = 1'b1;
    adr8   = ADR_OUT;
    dat_i8 = 32'hFFFFFFFF;
    @(negedge sys_clk);
    we8    = 1'b0;
    dat_i8 = 32'd0;
    @(negedge sys_clk);
    chk("w8_out_read", dat_o8, 32'h000000FF);
    chk("w8_out_pad", {24'd0, out8}, 32'h000000FF);
    chk("w8_oe_pad", {24'd0, oe8}, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_bank_irq.md
# gpio_bank_irq

Parametrised GPIO bank; successor to the fixed 32-bit GPIO interface. Adds configurable pin width, a pad input synchroniser, per-pin debounce, rising/falling/level interrupt modes, write-1-to-clear status and atomic output set/clear. Sits between the simple register bus (write strobe, address, data) and the chip pads. Drives the pad output and output-enable lines and a single interrupt line to the interrupt controller.

## Interface
- GPIO_W, 32, number of pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (≥2).
- DEB_W, 4, debounce counter width per pin.
- sys_clk  in  1  clock; all logic on rising edge.
- sys_rst  in  1  reset; synchronous, active-high.
- gpio_we  in  1  write strobe; one write per cycle when high.
- gpio_adr  in  8  byte address; bits [1:0] ignored.
- gpio_dat_i  in  32  write data; bits ≥ GPIO_W ignored.
- gpio_dat_o  out  32  registered read data; zero-extended above GPIO_W.
- gpio_inta_o  out  1  interrupt, active-high.
- out_pad_o  out  GPIO_W  pad output value.
- oen_padoe_o  out  GPIO_W  pad output enable (1 = drive).
- in_pad_i  in  GPIO_W  asynchronous pad input.

## Operation
- Register map (unmapped: write ignored, read 0):
  - 0x00 IN (RO): debounced input.
  - 0x04 OUT (RW).
  - 0x08 OE (RW).
  - 0x0C INTE (RW): per-pin interrupt enable.
  - 0x10 PTRIG (RW): rising edge / level-high.
  - 0x14 NTRIG (RW): falling edge / level-low.
  - 0x18 CTRL: bit0 INTE global (RW); bit1 INTS summary (RO).
  - 0x1C INTS: write-1-to-clear.
  - 0x20 OUT_SET: W1S on OUT; reads 0.
  - 0x24 OUT_CLR: W1C on OUT; reads 0.
  - 0x28 DEB (RW, DEB_W bits): debounce threshold.
  - 0x2C LEVEL (RW): 1 = level mode for that pin.
- Input path: in_pad_i → SYNC_STAGES flops → debounce → deb (the IN value).
- Debounce per pin: DEB=0 bypass (deb = synchroniser output). Otherwise:
  - When sync ≠ deb, counter increments.
  - When counter reaches DEB, deb takes the sync value and the counter clears.
  - When sync = deb, counter clears.
  - A pulse shorter than DEB cycles never reaches deb.
- Edge mode (LEVEL=0): INTS[i] sets when INTE[i] is set and deb[i] rises with PTRIG[i], or falls with NTRIG[i] (compared against deb of the previous cycle).
- Level mode (LEVEL=1): INTS[i] sets every cycle while INTE[i] is set and deb[i] is high with PTRIG[i], or low with NTRIG[i].
- Simultaneous set and W1C on the same bit: set wins.
- gpio_inta_o = CTRL.INTE & |INTS, combinational from flops.
- out_pad_o = OUT; oen_padoe_o = OE.

## Timing
- Reset: all registers, sync/debounce state, counters, gpio_dat_o, gpio_inta_o, out_pad_o and oen_padoe_o go to 0. Reset mid-debounce discards the count.
- Write: takes effect at the clock edge where gpio_we=1. OUT/OE reach the pads the same edge.
- Read: gpio_dat_o is valid one cycle after the address is presented with gpio_we=0. It holds its last value during write cycles.
- Pad → IN latency: SYNC_STAGES cycles (DEB=0); SYNC_STAGES+DEB cycles otherwise.
- deb edge → INTS set: next edge. gpio_inta_o follows with no added delay.
- Changing DEB mid-count: the new threshold applies from the next cycle. A count already ≥ new DEB updates deb immediately.

## Structure
- Package gpio_pkg holds the address localparams and CTRL bit indices.
- One sub-module: gpio_debounce (single pin; synchroniser plus counter, DEB_W-wide threshold input), instantiated GPIO_W times via generate.

## Test plan
- Reset asserted 2 cycles → all outputs 0; read of every address returns 0.
- OE=FFFF0000, OUT=A5A5A5A5 → oen_padoe_o FFFF0000, out_pad_o A5A5A5A5. Then OUT_SET=0000000A → out_pad_o A5A5A5AF. Then OUT_CLR=00000005 → out_pad_o A5A5A5AA.
- DEB=0, in_pad_i=12345678 → IN reads 12345678 within SYNC_STAGES+1 cycles.
- DEB=3, 2-cycle high glitch on pin0 → IN[0] stays 0, INTS stays 0. Pin0 held high 6 cycles → IN[0]=1 exactly SYNC_STAGES+3 cycles after the change.
- INTE=3, PTRIG=1, NTRIG=2, CTRL=1:
  - pin0 0→1 → INTS=1, gpio_inta_o=1.
  - pin1 1→0 → INTS=3.
  - Write INTS=1 → INTS=2.
  - W1C in the same cycle as a new edge → bit stays 1.
- LEVEL=1, PTRIG=1, INTE=1, CTRL=1, pin0 held high:
  - Write INTS=1 → INTS[0] remains 1.
  - Pin low, then INTS=1 → INTS=0, gpio_inta_o=0.
  - Repeat with GPIO_W=8: OUT write FFFFFFFF reads 000000FF.
